// File: rtl/timing_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timing_ctrl_pkg
// Shared types and constants for the timing phase sequencer.
//   state_e      : sequencer FSM state encoding (ST_IDLE, ST_RUN)
//   FRAME_CNT_W  : width of the optional frame counter output
// -----------------------------------------------------------------------------
package timing_ctrl_pkg;

    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : timing_ctrl_pkg

// File: rtl/timing_phase_ctrl_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Modulo counter that counts 0..len-1 while enabled and wraps to 0.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   clr   : force the count back to 0 (wins over en)
//   en    : advance the count this cycle
//   len   : modulus (phase length); must be non-zero while en is high
//   q     : current count
//   term  : q is at len-1 and the counter is enabled (last cycle of the phase)
// -----------------------------------------------------------------------------
module phase_counter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] len,
    output logic [N-1:0] q,
    output logic         term
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    assign term = en && (q_q == (len - N'(1)));
    assign q    = q_q;

    // Next count: clear, wrap on terminal, otherwise increment when enabled
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (term) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule : phase_counter

// File: rtl/timing_phase_ctrl.sv
// -----------------------------------------------------------------------------
// timing_phase_ctrl
// Sequencer for the timing generator. Steps through up to NUM_PHASES
// programmable-length phases, skipping zero-length slots, one-shot or
// continuously.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   cfg_we      : write strobe for the phase length table
//   cfg_addr    : table slot to write
//   cfg_len     : phase length in cycles (0 = slot skipped)
//   continuous  : 1 = restart at first non-zero slot after a frame
//   start       : begin a frame from IDLE
//   stop        : abort to IDLE (highest priority)
//   hold        : freeze count and phase
//   busy        : sequencer is running
//   phase_idx   : current phase slot
//   q_out       : count within the current phase, 0..L-1
//   phase_start : first cycle of each entered phase
//   frame_done  : last cycle of the last non-zero phase
//   cfg_err     : one-cycle pulse when start/wrap finds all lengths zero
//   frame_cnt   : frames completed since start (only with TIMING_FRAME_CNT_EN)
// Optional feature macro: TIMING_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module timing_phase_ctrl
    import timing_ctrl_pkg::*;
#(
    parameter  int unsigned N          = 8,
    parameter  int unsigned NUM_PHASES = 4,
    localparam int unsigned PW         = $clog2(NUM_PHASES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_len,
    input  logic          continuous,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    output logic          busy,
    output logic [PW-1:0] phase_idx,
    output logic [N-1:0]  q_out,
    output logic          phase_start,
    output logic          frame_done,
    output logic          cfg_err
`ifdef TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    // Sequencer state
    state_e        state_q,       state_d;
    logic [PW-1:0] phase_idx_q,   phase_idx_d;
    logic [N-1:0]  cur_len_q,     cur_len_d;
    logic          phase_start_q, phase_start_d;
    logic          cfg_err_q,     cfg_err_d;

    // Phase length table
    logic [N-1:0]  len_tbl_q [NUM_PHASES];

    // Priority search results
    logic          first_found;
    logic [PW-1:0] first_idx;
    logic          next_found;
    logic [PW-1:0] next_idx;

    // Counter interface
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_term;
    logic [N-1:0]  cnt_q;

    assign cnt_clr = stop || (state_q == ST_IDLE);
    assign cnt_en  = (state_q == ST_RUN) && !hold && !stop;

    phase_counter #(
        .N (N)
    ) u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .len   (cur_len_q),
        .q     (cnt_q),
        .term  (cnt_term)
    );

    // Table write, allowed in any state; entry latching sees the pre-write value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PHASES); i++) begin
                len_tbl_q[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_addr) < NUM_PHASES)) begin
            len_tbl_q[cfg_addr] <= cfg_len;
        end
    end

    // Lowest non-zero slot overall, and lowest non-zero slot above the current one
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = int'(NUM_PHASES) - 1; i >= 0; i--) begin
            if (len_tbl_q[i] != '0) begin
                first_found = 1'b1;
                first_idx   = PW'(i);
            end
            if ((i > int'(phase_idx_q)) && (len_tbl_q[i] != '0)) begin
                next_found = 1'b1;
                next_idx   = PW'(i);
            end
        end
    end

    // Next-state logic; stop dominates everything
    always_comb begin
        state_d       = state_q;
        phase_idx_d   = phase_idx_q;
        cur_len_d     = cur_len_q;
        phase_start_d = 1'b0;
        cfg_err_d     = 1'b0;

        if (stop) begin
            state_d     = ST_IDLE;
            phase_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (first_found) begin
                            state_d       = ST_RUN;
                            phase_idx_d   = first_idx;
                            cur_len_d     = len_tbl_q[first_idx];
                            phase_start_d = 1'b1;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_term) begin
                        if (next_found) begin
                            phase_idx_d   = next_idx;
                            cur_len_d     = len_tbl_q[next_idx];
                            phase_start_d = 1'b1;
                        end else if (continuous && first_found) begin
                            phase_idx_d   = first_idx;
                            cur_len_d     = len_tbl_q[first_idx];
                            phase_start_d = 1'b1;
                        end else begin
                            // End of one-shot frame, or table emptied under a continuous run
                            state_d     = ST_IDLE;
                            phase_idx_d = '0;
                            cfg_err_d   = continuous;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    phase_idx_d = '0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phase_idx_q   <= '0;
            cur_len_q     <= '0;
            phase_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_idx_q   <= phase_idx_d;
            cur_len_q     <= cur_len_d;
            phase_start_q <= phase_start_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign phase_idx   = phase_idx_q;
    assign q_out       = cnt_q;
    assign phase_start = phase_start_q;
    assign cfg_err     = cfg_err_q;
    // Terminal count already implies RUN, not held and not stopped
    assign frame_done  = cnt_term && !next_found;

`ifdef TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    // Completed-frame counter, restarted by each start from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule : timing_phase_ctrl

// File: doc/timing_phase_ctrl.md
Name: timing_phase_ctrl

Overview:
- Sequencer for the timing generator.
- Steps through up to NUM_PHASES programmable-length phases (e.g. sync / back porch / active / front porch) using an internal modulo phase counter.
- Emits the current phase index, per-phase start strobes and an end-of-frame strobe.
- Runs one-shot or continuously. Sits between the configuration interface and the downstream pulse/decoder logic.

Parameters:
- N, 8, width of phase length and count.
- NUM_PHASES, 4, number of phase slots (≥2).
- PW, $clog2(NUM_PHASES), phase index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for phase length table.
- cfg_addr  in  PW  phase slot to write.
- cfg_len  in  N  phase length in cycles; 0 = phase skipped.
- continuous  in  1  1 = wrap to first phase after frame; 0 = one-shot.
- start  in  1  begin frame from IDLE.
- stop  in  1  abort to IDLE.
- hold  in  1  freeze count and phase (like counter enable low).
- busy  out  1  state != IDLE.
- phase_idx  out  PW  current phase.
- q_out  out  N  count within phase, 0..L-1.
- phase_start  out  1  high in first cycle of each entered phase.
- frame_done  out  1  high in last cycle of last non-zero phase.
- cfg_err  out  1  one-cycle pulse: start/wrap found all lengths zero.

Behaviour:
- Reset, synchronous:
  - State IDLE.
  - All table entries 0.
  - Outputs busy, phase_idx, q_out, phase_start, frame_done and cfg_err all 0.
- Table write:
  - cfg_we writes len_tbl[cfg_addr] at the clock edge, in any state.
- Length latching:
  - Running phase uses cur_len, latched at phase entry.
  - A write to the active slot affects only its next entry.
  - Same-cycle write and phase entry: the old table value is latched.
- FSM states: IDLE, RUN.
- IDLE + start:
  - Search slots upward from 0 for the first non-zero length.
  - If found: RUN next cycle with phase_idx = that slot, q_out=0, phase_start=1.
  - If none: stay IDLE, cfg_err=1 for one cycle.
- RUN + hold=1: q_out, phase_idx and state frozen; phase_start and frame_done forced 0.
- RUN + hold=0, q_out < cur_len-1: q_out increments.
- RUN + hold=0, q_out == cur_len-1 (terminal):
  - Next phase = next higher slot with non-zero length; zero slots consume no cycles.
  - If one exists: move there next cycle, q_out=0, phase_start=1.
  - If none, this is the last phase: frame_done=1 this cycle.
    - continuous=1: restart at first non-zero slot from 0. If the table is now all zero, go IDLE with cfg_err=1.
    - continuous=0: go IDLE next cycle.
- stop:
  - Any state: IDLE next cycle, q_out=0, phase_idx=0.
  - stop overrides hold, start and terminal transitions; no frame_done/phase_start in the stop cycle's successor.
- start while RUN: ignored.
- Register and output timing:
  - phase_start is registered.
  - frame_done is decoded from registered state (terminal and last and !hold).
- Phase/frame length:
  - Phase of length L lasts exactly L unheld cycles.
  - Frame length = sum of non-zero lengths. Minimum phase 1 cycle; maximum 2^N-1.

Optional Feature:
- Macro: TIMING_FRAME_CNT_EN.
- Defined:
  - Extra output frame_cnt [15:0].
  - Increments on each frame_done, wraps 0xFFFF→0.
  - Cleared by reset and by start from IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package timing_ctrl_pkg: state enum (ST_IDLE, ST_RUN), FRAME_CNT_W = 16.
- Sub-module phase_counter:
  - Loadable modulo counter: inputs clk, reset, clr, en, len.
  - Outputs q, term (q == len-1 && en).
- The top holds the FSM, length table and next-non-zero-slot priority search.

Test Plan:
- Table {3,0,2,4}, continuous=0, start at cycle 0 →
  - phase_idx 0,0,0,2,2,3,3,3,3; q_out 0,1,2,0,1,0,1,2,3.
  - phase_start at cycles 0,3,5; frame_done at cycle 8; busy=0 from cycle 9.
- Same table, continuous=1 → phase 0 re-entered at cycle 9 with phase_start; frame_done at cycles 8,17,26.
- hold high for cycles 4–6 during the first scenario → q_out frozen at 1 in phase 2; frame_done moves to cycle 11.
- All lengths 0, start → cfg_err pulse one cycle, busy stays 0. stop asserted with hold=1 in phase 3 → busy=0 next cycle, q_out=0, no frame_done.
- cfg_we writes slot 2 = 5 while in phase 2 → current phase still 2 cycles; next frame phase 2 lasts 5 cycles. reset asserted mid-RUN → all outputs 0 next cycle, table cleared.
- TIMING_FRAME_CNT_EN defined, continuous run of 3 frames → frame_cnt reads 1,2,3 after each frame_done. A new start from IDLE clears it to 0.
